score_credit_keeper: RTL and testbench

//  Downstream of the game controller. Accumulates score pulses into a 4-digit BCD score,

---
 rtl/score_credit_keeper.sv | 224 ++++++++++++++++++++++
 tb/tb_score_credit_keeper.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_credit_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : score_credit_keeper
//  Description : Accumulates score awards into a 4-digit BCD score with a
//                serial drain, tracks the high score, and debounces the coin
//                key into a saturating credit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_credit_keeper #(
  parameter int MAX_CREDITS     = 9,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  scoreUpdate,
  input  logic        startGame,
  input  logic        gameEnded,
  input  logic        coinN,
  output logic [3:0]  credits,
  output logic [15:0] score_bcd,
  output logic [15:0] hiscore_bcd,
  output logic        busy,
  output logic        score_sat
);

  localparam int               CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DB_ONE    = CNT_W'(1);
  localparam logic [3:0]       MAX_C     = 4'(MAX_CREDITS);
  localparam logic [15:0]      SCORE_TOP = 16'h9999;

  typedef enum logic [1:0] {
    ST_ATTRACT = 2'd0,
    ST_PLAY    = 2'd1,
    ST_END     = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             start_prev, end_prev;
  logic             start_rise, end_rise;
  logic             coin_s1, coin_s2, coin_armed, coin_evt, db_match;
  logic [CNT_W-1:0] db_cnt;
  logic             credit_dec;
  logic [9:0]       pending, pend_next, pend_cur;
  logic [10:0]      pend_sum;
  logic [15:0]      score_next, hi_next;
  logic             sat_next, start_pend, start_pend_next;
  logic [16:0]      inc_res;

  // Adds one to the units digit (or the tens digit) with BCD ripple;
  // bit 16 of the result is the carry out of the thousands digit.
  function automatic logic [16:0] bcd_inc(input logic [15:0] val, input logic tens);
    logic [15:0] res;
    logic        carry;
    logic [3:0]  dig;
    res   = val;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      dig = val[d*4 +: 4];
      if (carry && !(d == 0 && tens)) begin
        if (dig == 4'd9) begin
          res[d*4 +: 4] = 4'd0;
          carry         = 1'b1;
        end else begin
          res[d*4 +: 4] = dig + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return {carry, res};
  endfunction

  assign start_rise = startGame & ~start_prev;
  assign end_rise   = gameEnded & ~end_prev;

  // Previous-cycle copies of the controller levels for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_prev <= 1'b0;
      end_prev   <= 1'b0;
    end else begin
      start_prev <= startGame;
      end_prev   <= gameEnded;
    end
  end

  // Two-flop synchroniser for the asynchronous coin key (idle high).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coin_s1 <= 1'b1;
      coin_s2 <= 1'b1;
    end else begin
      coin_s1 <= coinN;
      coin_s2 <= coin_s1;
    end
  end

  // When armed we count low samples toward a press; once a press is taken we
  // count high samples toward re-arming, so each press yields one event.
  assign db_match = coin_armed ? ~coin_s2 : coin_s2;

  // Debounce counter: a run of DEBOUNCE_CYCLES matching samples flips arming.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt     <= '0;
      coin_armed <= 1'b1;
      coin_evt   <= 1'b0;
    end else begin
      coin_evt <= 1'b0;
      if (!db_match) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt     <= '0;
        coin_armed <= ~coin_armed;
        coin_evt   <= coin_armed;
      end else begin
        db_cnt <= db_cnt + DB_ONE;
      end
    end
  end

  assign credit_dec = start_rise && (credits != 4'd0);

  // Credit counter: coin and start together cancel; saturate at the top, never underflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits <= 4'd0;
    end else if (coin_evt && !credit_dec) begin
      if (credits < MAX_C) credits <= credits + 4'd1;
    end else if (!coin_evt && credit_dec) begin
      credits <= credits - 4'd1;
    end
  end

  // Game state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_ATTRACT;
    else       state <= state_next;
  end

  // Next-state, award accumulation and one drain step per cycle.
  always_comb begin
    state_next      = state;
    score_next      = score_bcd;
    hi_next         = hiscore_bcd;
    sat_next        = score_sat;
    start_pend_next = start_pend;
    pend_next       = pending;
    pend_sum        = {1'b0, pending};
    pend_cur        = pending;
    inc_res         = '0;

    case (state)
      ST_ATTRACT: begin
        if (start_rise || start_pend) begin
          state_next      = ST_PLAY;
          score_next      = 16'h0000;
          sat_next        = 1'b0;
          start_pend_next = 1'b0;
        end
      end
      ST_PLAY: begin
        if (scoreUpdate != 8'd0) pend_sum = {1'b0, pending} + {3'b000, scoreUpdate};
        if (end_rise) state_next = ST_END;
      end
      ST_END: begin
        // A new game requested while finishing is remembered for ATTRACT.
        if (start_rise) start_pend_next = 1'b1;
        if (!busy) begin
          if (score_bcd > hiscore_bcd) hi_next = score_bcd;
          state_next = ST_ATTRACT;
        end
      end
      default: state_next = ST_ATTRACT;
    endcase

    if (state == ST_ATTRACT) begin
      // Awards are ignored and nothing is pending outside a game.
      pend_next = (start_rise || start_pend) ? 10'd0 : pending;
    end else begin
      pend_cur = (pend_sum > 11'd1023) ? 10'h3FF : pend_sum[9:0];
      if (pend_cur >= 10'd10) begin
        inc_res   = bcd_inc(score_bcd, 1'b1);
        pend_next = pend_cur - 10'd10;
      end else if (pend_cur != 10'd0) begin
        inc_res   = bcd_inc(score_bcd, 1'b0);
        pend_next = pend_cur - 10'd1;
      end else begin
        pend_next = pend_cur;
      end
      if (pend_cur != 10'd0) begin
        if (inc_res[16]) begin
          // Overflow past 9999: pin the score and drop whatever is left.
          score_next = SCORE_TOP;
          sat_next   = 1'b1;
          pend_next  = 10'd0;
        end else begin
          score_next = inc_res[15:0];
        end
      end
    end
  end

  // Score datapath registers; busy tracks the registered pending count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_bcd   <= 16'h0000;
      hiscore_bcd <= 16'h0000;
      score_sat   <= 1'b0;
      pending     <= 10'd0;
      busy        <= 1'b0;
      start_pend  <= 1'b0;
    end else begin
      score_bcd   <= score_next;
      hiscore_bcd <= hi_next;
      score_sat   <= sat_next;
      pending     <= pend_next;
      busy        <= (pend_next != 10'd0);
      start_pend  <= start_pend_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_score_credit_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_credit_keeper
//  Description : Directed self-checking bench for score_credit_keeper.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_credit_keeper;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  scoreUpdate = 8'd0;
  logic        startGame = 1'b0;
  logic        gameEnded = 1'b0;
  logic        coinN = 1'b1;
  logic [3:0]  credits;
  logic [15:0] score_bcd;
  logic [15:0] hiscore_bcd;
  logic        busy;
  logic        score_sat;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  score_credit_keeper #(
    .MAX_CREDITS    (9),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .scoreUpdate(scoreUpdate),
    .startGame  (startGame),
    .gameEnded  (gameEnded),
    .coinN      (coinN),
    .credits    (credits),
    .score_bcd  (score_bcd),
    .hiscore_bcd(hiscore_bcd),
    .busy       (busy),
    .score_sat  (score_sat)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_val(input string tag, input logic [31:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic check_val(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      tick(1);
      n++;
    end
    expect_val("idle_in_time", 32'd1);
    check_val({31'd0, busy === 1'b0});
  endtask

  task automatic press_coin();
    coinN = 1'b0;
    tick(8);
    coinN = 1'b1;
    tick(8);
  endtask

  task automatic start_game();
    startGame = 1'b1;
    tick(2);
    startGame = 1'b0;
    tick(1);
  endtask

  task automatic end_game();
    gameEnded = 1'b1;
    tick(1);
    gameEnded = 1'b0;
    tick(3);
  endtask

  task automatic award(input logic [7:0] pts);
    scoreUpdate = pts;
    tick(1);
    scoreUpdate = 8'd0;
  endtask

  initial begin
    // Reset state
    tick(2);
    expect_val("rst_credits", 32'd0);
    expect_val("rst_score", 32'h0);
    expect_val("rst_hiscore", 32'h0);
    expect_val("rst_busy", 32'd0);
    expect_val("rst_sat", 32'd0);
    check_val(32'(credits));
    check_val(32'(score_bcd));
    check_val(32'(hiscore_bcd));
    check_val(32'(busy));
    check_val(32'(score_sat));
    reset = 1'b0;
    tick(1);

    // One debounced press, then a short glitch that must be rejected
    expect_val("coin_accept", 32'd1);
    press_coin();
    check_val(32'(credits));
    expect_val("coin_glitch", 32'd1);
    coinN = 1'b0;
    tick(2);
    coinN = 1'b1;
    tick(10);
    check_val(32'(credits));

    // Saturation at 9 after 12 accepted coins, then start costs one credit
    expect_val("credits_sat", 32'd9);
    repeat (11) press_coin();
    check_val(32'(credits));
    expect_val("g1_credits", 32'd8);
    expect_val("g1_score", 32'h0);
    start_game();
    check_val(32'(credits));
    check_val(32'(score_bcd));

    // 30 then 100 three cycles later: 13 drain cycles in total
    scoreUpdate = 8'd30;
    tick(1);
    scoreUpdate = 8'd0;
    tick(2);
    scoreUpdate = 8'd100;
    tick(1);
    scoreUpdate = 8'd0;
    expect_val("drain12_busy", 32'd1);
    expect_val("drain12_score", 32'h0120);
    tick(8);
    check_val(32'(busy));
    check_val(32'(score_bcd));
    expect_val("drain13_busy", 32'd0);
    expect_val("drain13_score", 32'h0130);
    tick(1);
    check_val(32'(busy));
    check_val(32'(score_bcd));

    // Game 1 ends at 0130
    expect_val("g1_hiscore", 32'h0130);
    expect_val("g1_score_held", 32'h0130);
    end_game();
    check_val(32'(hiscore_bcd));
    check_val(32'(score_bcd));

    // Awards in ATTRACT are ignored
    expect_val("attract_score", 32'h0130);
    expect_val("attract_busy", 32'd0);
    award(8'd50);
    tick(3);
    check_val(32'(score_bcd));
    check_val(32'(busy));

    // Game 2 ends lower: high score kept
    expect_val("g2_credits", 32'd7);
    start_game();
    check_val(32'(credits));
    award(8'd90);
    wait_idle(50);
    expect_val("g2_score", 32'h0090);
    check_val(32'(score_bcd));
    expect_val("g2_hiscore", 32'h0130);
    end_game();
    check_val(32'(hiscore_bcd));

    // Game 3: end with 7 pending, request a new game while finishing
    start_game();
    award(8'd140);
    wait_idle(50);
    scoreUpdate = 8'd7;
    gameEnded   = 1'b1;
    expect_val("g3_end_busy", 32'd1);
    expect_val("g3_end_hiscore", 32'h0130);
    tick(1);
    scoreUpdate = 8'd0;
    gameEnded   = 1'b0;
    check_val(32'(busy));
    check_val(32'(hiscore_bcd));
    startGame = 1'b1;
    tick(1);
    startGame = 1'b0;
    wait_idle(20);
    expect_val("g3_drained_hiscore", 32'h0130);
    expect_val("g3_drained_score", 32'h0147);
    check_val(32'(hiscore_bcd));
    check_val(32'(score_bcd));
    expect_val("g3_hiscore", 32'h0147);
    expect_val("g3_score_held", 32'h0147);
    tick(1);
    check_val(32'(hiscore_bcd));
    check_val(32'(score_bcd));
    expect_val("g4_auto_score", 32'h0);
    expect_val("g4_credits", 32'd5);
    tick(1);
    check_val(32'(score_bcd));
    check_val(32'(credits));

    // Game 4: climb to 9990, then 25 more saturates at 9999
    repeat (39) begin
      award(8'd255);
      wait_idle(60);
    end
    award(8'd45);
    wait_idle(20);
    expect_val("g4_score_9990", 32'h9990);
    expect_val("g4_sat_before", 32'd0);
    check_val(32'(score_bcd));
    check_val(32'(score_sat));
    expect_val("g4_score_top", 32'h9999);
    expect_val("g4_sat", 32'd1);
    expect_val("g4_pending_clear", 32'd0);
    award(8'd25);
    check_val(32'(score_bcd));
    check_val(32'(score_sat));
    check_val(32'(busy));
    expect_val("g4_hiscore", 32'h9999);
    end_game();
    check_val(32'(hiscore_bcd));

    // Game 5: new game clears saturation; reset mid-drain clears everything
    expect_val("g5_sat", 32'd0);
    expect_val("g5_score", 32'h0);
    expect_val("g5_credits", 32'd4);
    start_game();
    check_val(32'(score_sat));
    check_val(32'(score_bcd));
    check_val(32'(credits));
    expect_val("g5_busy", 32'd1);
    award(8'd200);
    tick(3);
    check_val(32'(busy));
    reset = 1'b1;
    expect_val("mid_rst_credits", 32'd0);
    expect_val("mid_rst_score", 32'h0);
    expect_val("mid_rst_hiscore", 32'h0);
    expect_val("mid_rst_busy", 32'd0);
    expect_val("mid_rst_sat", 32'd0);
    #1;
    check_val(32'(credits));
    check_val(32'(score_bcd));
    check_val(32'(hiscore_bcd));
    check_val(32'(busy));
    check_val(32'(score_sat));
    tick(1);
    reset = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
